cordic_share_arbiter: RTL and testbench
=======================================

Name: cordic_share_arbiter

Overview:
Shares one iterative 12-bit CORDIC sin/cos engine between two requesters: requester 0 is the PWM audio waveform path and requester 1 is the VGA trace/plot path. Requests are accepted with a valid/ready handshake and arbitrated round-robin. The engine is sequenced with a start/done handshake. Each result is returned to the requester that issued it. A watchdog aborts any engine operation that never completes.

Parameters:
WIDTH, 12, angle and result width in bits (two's complement sin/cos)
TIMEOUT, 31, max cycles in WAIT before abort; must be ≥1; timer width = $clog2(TIMEOUT+1)

Ports:
clk1  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an angle pending
req0_angle  input  WIDTH  requester 0 angle; held stable while valid and not ready
req0_ready  output  1  request 0 accepted this cycle
rsp0_valid  output  1  one-cycle pulse: result for requester 0
rsp0_err  output  1  qualifies rsp0_valid: watchdog abort, data is 0
rsp0_sin  output  WIDTH  sin result for requester 0
rsp0_cos  output  WIDTH  cos result for requester 0
req1_valid, req1_angle, req1_ready, rsp1_valid, rsp1_err, rsp1_sin, rsp1_cos: as above, for requester 1
core_start  output  1  one-cycle start pulse to the CORDIC engine
core_angle  output  WIDTH  registered angle presented to the engine
core_done  input  1  engine result valid (single-cycle pulse)
core_sin  input  WIDTH  engine sin output, valid with core_done
core_cos  input  WIDTH  engine cos output, valid with core_done

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie)
  - all outputs 0, including core_angle and the rsp data registers
  - reset mid-operation abandons the transaction; no response is emitted
  - engine results arriving after reset are ignored
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - winner = the only valid requester; if both are valid, winner = requester != last_grant
  - reqN_ready is combinational: high only for the winner, only in IDLE
  - on handshake: latch angle into core_angle, latch owner=N, go to ISSUE
  - no request valid: stay in IDLE
- ISSUE: core_start=1 for exactly one cycle; clear timer; go to WAIT.
- WAIT:
  - core_done=1: latch core_sin/core_cos, err=0, go to RESP
  - else timer==TIMEOUT: data=0, err=1, go to RESP
  - else timer++
  - if core_done and timeout coincide, done wins (err=0)
- RESP:
  - rsp<owner>_valid=1 for one cycle, with registered sin/cos/err
  - the other requester's rsp outputs stay 0
  - last_grant<=owner; go to IDLE
- core_done outside WAIT is ignored: no state change, no data latch.
- Latency: handshake at cycle T → core_start at T+1 → done at cycle D → rsp valid at D+1.
  - Minimum request-to-response is 3 cycles, with done arriving at T+2.
  - Next accept is possible at D+2 (IDLE).
- Responses have no backpressure; requesters must sample rsp*_valid when it pulses.
- Only one transaction is in flight; requests are never dropped, they wait in valid.
- rsp data registers hold their last values when valid=0; the bench checks data only when valid=1.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package cordic_pkg:
  - WIDTH default constant
  - state typedef enum {IDLE, ISSUE, WAIT, RESP}
  - typedef of a result struct {sin, cos, err}
- One sub-module: rr_arb2 (two-input round-robin winner select from valid and last_grant; combinational).
- Instantiate cordic_share_arbiter inside the CORDIC top, between the waveform/PWM logic and the VGA logic and the shared engine.

Test Plan:
- Single request: req0_valid with angle=12'h400, engine done 14 cycles after start with sin=12'h7FF, cos=12'h000 → req0_ready at T, core_start at T+1, rsp0_valid at T+16 with those values, err=0; rsp1_valid stays 0.
- Simultaneous requests right after reset, both valid, angles 12'h100 and 12'h200 → req0 served first (core_angle=12'h100), then req1 (core_angle=12'h200); each response goes only to its owner.
- Both valid for 6 transactions → grant order 0,1,0,1,0,1; no grant twice in a row.
- Watchdog: the engine never asserts done → rsp0_valid with rsp0_err=1 and sin=cos=0 exactly TIMEOUT+1 cycles after the WAIT entry cycle; the arbiter then accepts the next request.
- Coincident done and timeout: core_done arrives on the cycle timer==TIMEOUT → err=0 and the data is latched.
- Reset in WAIT, then core_done pulses → no rsp pulses, state IDLE, next request wins with req0 priority; a spurious core_done in IDLE causes no response.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC engine sharing arbiter.
package cordic_pkg;

   localparam int CORDIC_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [CORDIC_WIDTH-1:0] sin;
      logic [CORDIC_WIDTH-1:0] cos;
      logic                    err;
   } result_t;

endpackage

// File: rtl/cordic_share_arbiter_if.sv
// Requester and engine signal bundle. The slave side is the arbiter; the master side is
// the requesters plus the CORDIC engine.
interface cordic_share_arbiter_if
   import cordic_pkg::*;
#(
   parameter int WIDTH = CORDIC_WIDTH
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_angle;
   logic             req0_ready;
   logic             rsp0_valid;
   logic             rsp0_err;
   logic [WIDTH-1:0] rsp0_sin;
   logic [WIDTH-1:0] rsp0_cos;

   logic             req1_valid;
   logic [WIDTH-1:0] req1_angle;
   logic             req1_ready;
   logic             rsp1_valid;
   logic             rsp1_err;
   logic [WIDTH-1:0] rsp1_sin;
   logic [WIDTH-1:0] rsp1_cos;

   logic             core_start;
   logic [WIDTH-1:0] core_angle;
   logic             core_done;
   logic [WIDTH-1:0] core_sin;
   logic [WIDTH-1:0] core_cos;

   modport slave (
      input  req0_valid, req0_angle, req1_valid, req1_angle,
      input  core_done, core_sin, core_cos,
      output req0_ready, rsp0_valid, rsp0_err, rsp0_sin, rsp0_cos,
      output req1_ready, rsp1_valid, rsp1_err, rsp1_sin, rsp1_cos,
      output core_start, core_angle
   );

   modport master (
      output req0_valid, req0_angle, req1_valid, req1_angle,
      output core_done, core_sin, core_cos,
      input  req0_ready, rsp0_valid, rsp0_err, rsp0_sin, rsp0_cos,
      input  req1_ready, rsp1_valid, rsp1_err, rsp1_sin, rsp1_cos,
      input  core_start, core_angle
   );

endinterface

// File: rtl/cordic_share_arbiter_rr_arb2.sv
// Two-input round-robin winner select; purely combinational. On a tie the requester
// that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_vld_o,
   output logic       grant_idx_o
);

   assign grant_vld_o = |valid_i;
   assign grant_idx_o = (valid_i == 2'b11) ? ~last_grant_i : valid_i[1];

endmodule

// File: rtl/cordic_share_arbiter.sv
// Shares one iterative CORDIC sin/cos engine between two requesters, round-robin,
// one transaction in flight, with a watchdog that aborts a hung engine operation.
module cordic_share_arbiter
   import cordic_pkg::*;
#(
   parameter int WIDTH   = CORDIC_WIDTH,
   parameter int TIMEOUT = 31
) (
   input logic                   clk1,
   input logic                   reset,
   cordic_share_arbiter_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]            state_q,      state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q,      owner_d;
   logic [WIDTH-1:0]      angle_q,      angle_d;
   logic [TW-1:0]         timer_q,      timer_d;
   logic [1:0][WIDTH-1:0] sin_q,        sin_d;
   logic [1:0][WIDTH-1:0] cos_q,        cos_d;
   logic [1:0]            err_q,        err_d;

   logic grant_vld;
   logic grant_idx;

   rr_arb2 u_arb (
      .valid_i      ({bus.req1_valid, bus.req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_vld_o  (grant_vld),
      .grant_idx_o  (grant_idx)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      angle_d      = angle_q;
      timer_d      = timer_q;
      sin_d        = sin_q;
      cos_d        = cos_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               angle_d = grant_idx ? bus.req1_angle : bus.req0_angle;
               owner_d = grant_idx;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done on the final watchdog cycle still counts as a good result.
            if (bus.core_done) begin
               sin_d[owner_q] = bus.core_sin;
               cos_d[owner_q] = bus.core_cos;
               err_d[owner_q] = 1'b0;
               state_d        = S_RESP;
            end else if (timer_q == TW'(TIMEOUT)) begin
               sin_d[owner_q] = '0;
               cos_d[owner_q] = '0;
               err_d[owner_q] = 1'b1;
               state_d        = S_RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESP: begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         angle_q      <= '0;
         timer_q      <= '0;
         sin_q        <= '0;
         cos_q        <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         angle_q      <= angle_d;
         timer_q      <= timer_d;
         sin_q        <= sin_d;
         cos_q        <= cos_d;
         err_q        <= err_d;
      end
   end

   assign bus.req0_ready = (state_q == S_IDLE) && grant_vld && !grant_idx;
   assign bus.req1_ready = (state_q == S_IDLE) && grant_vld &&  grant_idx;

   assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
   assign bus.rsp1_valid = (state_q == S_RESP) &&  owner_q;
   assign bus.rsp0_err   = bus.rsp0_valid && err_q[0];
   assign bus.rsp1_err   = bus.rsp1_valid && err_q[1];
   assign bus.rsp0_sin   = sin_q[0];
   assign bus.rsp0_cos   = cos_q[0];
   assign bus.rsp1_sin   = sin_q[1];
   assign bus.rsp1_cos   = cos_q[1];

   assign bus.core_start = (state_q == S_ISSUE);
   assign bus.core_angle = angle_q;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed bench for cordic_share_arbiter: a vector table of single-requester transactions
// plus hand-written sequences for ties, fairness, reset mid-operation and stray done pulses.
module tb_cordic_share_arbiter;
   import cordic_pkg::*;

   localparam int TO = 31;

   logic clk1 = 1'b0;
   logic reset;
   always #5 clk1 = ~clk1;

   cordic_share_arbiter_if #(.WIDTH(CORDIC_WIDTH)) bus ();

   cordic_share_arbiter #(.WIDTH(CORDIC_WIDTH), .TIMEOUT(TO)) dut (
      .clk1  (clk1),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic        req;
      logic [11:0] angle;
      int          dly;
      logic [11:0] sin;
      logic [11:0] cos;
      result_t     exp;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.core_done  = 1'b0;
      repeat (2) @(negedge clk1);
      reset = 1'b0;
   endtask

   // Caller sets the request valids at a negedge; this waits for the grant, plays the
   // engine (done dly cycles after start, or never if dly<0) and checks the response.
   task automatic serve(input string tag, input int dly, input logic [11:0] s, input logic [11:0] c,
                        input logic own, input logic [11:0] ang, input result_t exp,
                        input int elat, input bit drop);
      int      n;
      int      lat;
      bit      got;
      logic [1:0] rv;
      result_t r;
      n = 0; lat = 0; got = 0; rv = 2'b00; r = '0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 40) begin
         @(negedge clk1); #1; n++;
      end
      check({tag, " grant"}, 32'({bus.req1_ready, bus.req0_ready}), own ? 32'd2 : 32'd1);
      @(posedge clk1);
      @(negedge clk1);
      if (drop) begin
         if (own) bus.req1_valid = 1'b0;
         else     bus.req0_valid = 1'b0;
      end
      check({tag, " start"}, 32'(bus.core_start), 32'd1);
      check({tag, " core_angle"}, 32'(bus.core_angle), 32'(ang));
      for (int j = 1; j <= 60 && !got; j++) begin
         if (j > 1) @(negedge clk1);
         bus.core_done = (j == dly + 1);
         bus.core_sin  = bus.core_done ? s : 12'hA5C;
         bus.core_cos  = bus.core_done ? c : 12'h3C5;
         if (j == 2) check({tag, " start pulse"}, 32'(bus.core_start), 32'd0);
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            got   = 1;
            lat   = j;
            rv    = {bus.rsp1_valid, bus.rsp0_valid};
            r.err = own ? bus.rsp1_err : bus.rsp0_err;
            r.sin = own ? bus.rsp1_sin : bus.rsp0_sin;
            r.cos = own ? bus.rsp1_cos : bus.rsp0_cos;
         end
      end
      @(negedge clk1);
      bus.core_done = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " rsp owner"}, 32'(rv), own ? 32'd2 : 32'd1);
      check({tag, " rsp err"}, 32'(r.err), 32'(exp.err));
      check({tag, " rsp sin"}, 32'(r.sin), 32'(exp.sin));
      check({tag, " rsp cos"}, 32'(r.cos), 32'(exp.cos));
      check({tag, " rsp pulse"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
   endtask

   task automatic count_rsp(input int cycles, output int cnt);
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk1);
         if (bus.rsp0_valid || bus.rsp1_valid || bus.core_start) cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   cnt;
      logic own;
      bus.req0_valid = 1'b0; bus.req0_angle = '0;
      bus.req1_valid = 1'b0; bus.req1_angle = '0;
      bus.core_done  = 1'b0; bus.core_sin   = '0; bus.core_cos = '0;
      reset = 1'b1;

      vecs[0] = '{"single r0",     1'b0, 12'h400, 14, 12'h7FF, 12'h000, '{12'h7FF, 12'h000, 1'b0}, 16};
      vecs[1] = '{"min latency r1", 1'b1, 12'h123,  1, 12'h0A5, 12'hF5A, '{12'h0A5, 12'hF5A, 1'b0},  3};
      vecs[2] = '{"timeout r0",    1'b0, 12'h800, -1, 12'h111, 12'h222, '{12'h000, 12'h000, 1'b1}, TO + 3};
      vecs[3] = '{"coincident r1", 1'b1, 12'h7FF, TO + 1, 12'h3A1, 12'hC5F, '{12'h3A1, 12'hC5F, 1'b0}, TO + 3};
      vecs[4] = '{"late done r0",  1'b0, 12'h001, TO + 2, 12'h456, 12'h789, '{12'h000, 12'h000, 1'b1}, TO + 3};
      vecs[5] = '{"short r1",      1'b1, 12'hFFF,  5, 12'h800, 12'h7FF, '{12'h800, 12'h7FF, 1'b0},  7};

      do_reset();
      #1;
      check("reset ctl", 32'({bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid,
                              bus.rsp1_err, bus.rsp0_err, bus.core_start}), 32'd0);
      check("reset core_angle", 32'(bus.core_angle), 32'd0);
      check("reset rsp data", 32'({bus.rsp0_sin, bus.rsp1_cos}), 32'd0);

      // Tie straight after reset: requester 0 first, then 1.
      @(negedge clk1);
      bus.req0_valid = 1'b1; bus.req0_angle = 12'h100;
      bus.req1_valid = 1'b1; bus.req1_angle = 12'h200;
      serve("tie first", 3, 12'h0AA, 12'h0BB, 1'b0, 12'h100, '{12'h0AA, 12'h0BB, 1'b0}, 5, 1'b1);
      serve("tie second", 3, 12'h0CC, 12'h0DD, 1'b1, 12'h200, '{12'h0CC, 12'h0DD, 1'b0}, 5, 1'b1);

      foreach (vecs[i]) begin
         if (vecs[i].req) begin bus.req1_valid = 1'b1; bus.req1_angle = vecs[i].angle; end
         else             begin bus.req0_valid = 1'b1; bus.req0_angle = vecs[i].angle; end
         serve(vecs[i].name, vecs[i].dly, vecs[i].sin, vecs[i].cos, vecs[i].req, vecs[i].angle,
               vecs[i].exp, vecs[i].lat, 1'b1);
      end

      // Continuous contention: grants must alternate 0,1,0,1,0,1.
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_angle = 12'h111;
      bus.req1_valid = 1'b1; bus.req1_angle = 12'h222;
      for (int i = 0; i < 6; i++) begin
         own = 1'(i % 2);
         serve($sformatf("fair %0d", i), 2, 12'(i + 16), 12'(i + 32), own,
               own ? 12'h222 : 12'h111, '{12'(i + 16), 12'(i + 32), 1'b0}, 4, 1'b0);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // Leave last_grant at 0, then abandon a requester-1 transaction by reset in WAIT.
      bus.req0_valid = 1'b1; bus.req0_angle = 12'h0F0;
      serve("pre abort", 2, 12'h101, 12'h202, 1'b0, 12'h0F0, '{12'h101, 12'h202, 1'b0}, 4, 1'b1);
      bus.req1_valid = 1'b1; bus.req1_angle = 12'h555;
      #1;
      check("abort grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
      @(posedge clk1);
      @(negedge clk1);
      bus.req1_valid = 1'b0;
      repeat (3) @(negedge clk1);
      reset = 1'b1;
      @(negedge clk1);
      reset = 1'b0;
      check("abort core_angle", 32'(bus.core_angle), 32'd0);
      bus.core_done = 1'b1; bus.core_sin = 12'h7FF; bus.core_cos = 12'h7FF;
      @(negedge clk1);
      bus.core_done = 1'b0;
      count_rsp(5, cnt);
      check("abort no rsp", 32'(cnt), 32'd0);
      bus.req0_valid = 1'b1; bus.req0_angle = 12'h321;
      bus.req1_valid = 1'b1; bus.req1_angle = 12'h654;
      serve("post reset r0", 4, 12'h0E1, 12'h0E2, 1'b0, 12'h321, '{12'h0E1, 12'h0E2, 1'b0}, 6, 1'b1);
      serve("post reset r1", 4, 12'h0E3, 12'h0E4, 1'b1, 12'h654, '{12'h0E3, 12'h0E4, 1'b0}, 6, 1'b1);

      // Stray done while idle must not produce anything.
      bus.core_done = 1'b1; bus.core_sin = 12'h333; bus.core_cos = 12'h444;
      @(negedge clk1);
      bus.core_done = 1'b0;
      count_rsp(4, cnt);
      check("idle done ignored", 32'(cnt), 32'd0);
      check("idle done data", 32'({bus.rsp1_sin, bus.rsp1_cos}), 32'({12'h0E3, 12'h0E4}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
